// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the five-stage RV32i pipeline.
// Optional performance counters are compiled in with HAZARD_PERF_CNT_EN.
module hazard_controller #(
  parameter int unsigned STALL_CNT_W = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] Rs1_D,
  input  logic [4:0] Rs2_D,
  input  logic [4:0] Rd_E,
  input  logic       Mem_Read_E,
  input  logic       PC_Src_E,
  input  logic       IMem_Ready,
  input  logic       DMem_Req_M,
  input  logic       DMem_Ready,
  output logic       Stall_F,
  output logic       Stall_D,
  output logic       Flush_D,
  output logic       Stall_E,
  output logic       Flush_E
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] Stall_Count,
  output logic [STALL_CNT_W-1:0] Flush_Count
`endif
);

  typedef enum logic [1:0] {RUN, DWAIT, IDROP} state_t;

  state_t state, state_nxt;
  logic   load_use;
  logic   dmem_busy;

  assign load_use  = Mem_Read_E && (Rd_E != 5'd0) && ((Rd_E == Rs1_D) || (Rd_E == Rs2_D));
  assign dmem_busy = DMem_Req_M && !DMem_Ready;

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

  // A data stall leaves IDROP pending: the stale fetch still has to be discarded.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN, DWAIT: begin
        if (dmem_busy)                     state_nxt = DWAIT;
        else if (PC_Src_E && !IMem_Ready)  state_nxt = IDROP;
        else                               state_nxt = RUN;
      end
      IDROP: begin
        if (dmem_busy || !IMem_Ready) state_nxt = IDROP;
        else                          state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Flush_D = 1'b0;
    Stall_E = 1'b0;
    Flush_E = 1'b0;
    if (!RST) begin
      if (dmem_busy) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Stall_E = 1'b1;
      end else if (PC_Src_E) begin
        Flush_D = 1'b1;
        Flush_E = 1'b1;
      end else if (load_use) begin
        Stall_F = 1'b1;
        Stall_D = 1'b1;
        Flush_E = 1'b1;
      end else if (state == IDROP) begin
        Flush_D = 1'b1;
        Stall_F = !IMem_Ready;
      end else if (!IMem_Ready) begin
        Stall_F = 1'b1;
        Flush_D = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic idrop_discard;

  assign idrop_discard = (state == IDROP) && !dmem_busy && !PC_Src_E && !load_use && IMem_Ready;

  always_ff @(posedge CLK) begin
    if (RST) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (Stall_F)                  Stall_Count <= Stall_Count + STALL_CNT_W'(1);
      if (Flush_E || idrop_discard) Flush_Count <= Flush_Count + STALL_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed-vector bench for hazard_controller; counter checks run when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_controller;

`ifdef HAZARD_PERF_CNT_EN
  localparam int unsigned W = 4;
`else
  localparam int unsigned W = 32;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] Rs1_D, Rs2_D, Rd_E;
  logic       Mem_Read_E, PC_Src_E, IMem_Ready, DMem_Req_M, DMem_Ready;
  logic       Stall_F, Stall_D, Flush_D, Stall_E, Flush_E;
`ifdef HAZARD_PERF_CNT_EN
  logic [W-1:0] Stall_Count, Flush_Count;
`endif

  int errors = 0;
  int checks = 0;
  logic [W-1:0] m_stall = '0;
  logic [W-1:0] m_flush = '0;

  hazard_controller #(.STALL_CNT_W(W)) dut (
    .CLK(CLK), .RST(RST),
    .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_E(Rd_E),
    .Mem_Read_E(Mem_Read_E), .PC_Src_E(PC_Src_E), .IMem_Ready(IMem_Ready),
    .DMem_Req_M(DMem_Req_M), .DMem_Ready(DMem_Ready),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D),
    .Stall_E(Stall_E), .Flush_E(Flush_E)
`ifdef HAZARD_PERF_CNT_EN
    , .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
`endif
  );

  always #5 CLK = ~CLK;

  // exp = {Stall_F, Stall_D, Flush_D, Stall_E, Flush_E}; disc marks the IDROP discard cycle
  typedef struct {
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       mr, pcs, imr, dreq, drdy;
    logic [4:0] exp;
    logic       disc;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                              logic mr, logic pcs, logic imr, logic dreq, logic drdy,
                              logic [4:0] exp, logic disc);
    vec_t v;
    v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.mr = mr; v.pcs = pcs; v.imr = imr; v.dreq = dreq; v.drdy = drdy;
    v.exp = exp; v.disc = disc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    RST = v.rst; Rs1_D = v.rs1; Rs2_D = v.rs2; Rd_E = v.rd;
    Mem_Read_E = v.mr; PC_Src_E = v.pcs; IMem_Ready = v.imr;
    DMem_Req_M = v.dreq; DMem_Ready = v.drdy;
    #2;
  endtask

  task automatic model(input vec_t v);
    if (v.rst) begin
      m_stall = '0;
      m_flush = '0;
    end else begin
      m_stall = m_stall + W'(v.exp[4]);
      m_flush = m_flush + W'(v.exp[0] | v.disc);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [4:0] outs();
    return {Stall_F, Stall_D, Flush_D, Stall_E, Flush_E};
  endfunction

  task automatic test_reset;
    vec_t q[$];
    q.push_back(mk(1, 5, 5, 5, 1, 1, 0, 1, 0, 5'b00000, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL reset[%0d] got=%b want=%b", i, outs(), q[i].exp);
      end
      model(q[i]);
      tick();
    end
  endtask

  task automatic test_load_use;
    vec_t q[$];
    q.push_back(mk(0, 1, 5, 5, 1, 0, 1, 0, 0, 5'b11001, 0));
    q.push_back(mk(0, 1, 5, 5, 0, 0, 1, 0, 0, 5'b00000, 0));
    q.push_back(mk(0, 5, 0, 0, 1, 0, 1, 0, 0, 5'b00000, 0));
    q.push_back(mk(0, 7, 3, 7, 1, 0, 1, 0, 0, 5'b11001, 0));
    q.push_back(mk(0, 7, 3, 7, 0, 0, 1, 0, 0, 5'b00000, 0));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL load_use[%0d] got=%b want=%b", i, outs(), q[i].exp);
      end
      model(q[i]);
      tick();
    end
  endtask

  task automatic test_redirect;
    vec_t q[$];
    q.push_back(mk(0, 4, 5, 5, 1, 1, 1, 0, 0, 5'b00101, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL redirect[%0d] got=%b want=%b", i, outs(), q[i].exp);
      end
      model(q[i]);
      tick();
    end
  endtask

  task automatic test_dmem_wait;
    vec_t q[$];
    q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 5'b11010, 0));
    q.push_back(mk(0, 0, 5, 5, 1, 1, 1, 1, 0, 5'b11010, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 5'b11010, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 5'b00101, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL dmem_wait[%0d] got=%b want=%b", i, outs(), q[i].exp);
      end
      model(q[i]);
      tick();
    end
  endtask

  task automatic test_idrop;
    vec_t q[$];
    q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00101, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00100, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0));
    // repeated redirect while the fetch is still pending
    q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00101, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00101, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00100, 1));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL idrop[%0d] got=%b want=%b", i, outs(), q[i].exp);
      end
      model(q[i]);
      tick();
    end
  endtask

  task automatic test_imem_wait;
    vec_t q[$];
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL imem_wait[%0d] got=%b want=%b", i, outs(), q[i].exp);
      end
      model(q[i]);
      tick();
    end
  endtask

  task automatic test_reset_mid;
    vec_t q[$];
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5'b11010, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 5'b00000, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 5'b00101, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 0));
    q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 0));
    foreach (q[i]) begin
      apply(q[i]);
      checks++;
      if (outs() !== q[i].exp) begin
        errors++;
        $display("FAIL reset_mid[%0d] got=%b want=%b", i, outs(), q[i].exp);
      end
      model(q[i]);
      tick();
    end
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_counters(input string tag);
    checks++;
    if (Stall_Count !== m_stall) begin
      errors++;
      $display("FAIL stall_count_%s got=%0d want=%0d", tag, Stall_Count, m_stall);
    end
    checks++;
    if (Flush_Count !== m_flush) begin
      errors++;
      $display("FAIL flush_count_%s got=%0d want=%0d", tag, Flush_Count, m_flush);
    end
  endtask

  task automatic test_counter_wrap;
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b10100, 0);
    for (int i = 0; i < (1 << W) - 1; i++) begin
      apply(v);
      model(v);
      tick();
    end
    checks++;
    if (Stall_Count !== {W{1'b1}}) begin
      errors++;
      $display("FAIL stall_count_max got=%0d want=%0d", Stall_Count, (1 << W) - 1);
    end
    apply(v);
    model(v);
    tick();
    checks++;
    if (Stall_Count !== '0) begin
      errors++;
      $display("FAIL stall_count_wrap got=%0d want=0", Stall_Count);
    end
    checks++;
    if (Flush_Count !== '0) begin
      errors++;
      $display("FAIL flush_count_wrap got=%0d want=0", Flush_Count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_dmem_wait();
    test_idrop();
    test_imem_wait();
`ifdef HAZARD_PERF_CNT_EN
    test_counters("run");
`endif
    test_reset_mid();
`ifdef HAZARD_PERF_CNT_EN
    test_counters("after_reset");
    test_counter_wrap();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Central pipeline sequencer for the five-stage RV32i core. Each cycle it computes the stall and flush controls for the PC register and for the fetch/decode, decode/execute and execute/memory pipeline registers. It handles load-use hazards, control-flow redirects, instruction-memory wait states and data-memory wait states. It sits beside the datapath and drives the `Stall_En`/`Flush_*` inputs of every pipeline register.

## Interface
Parameters:
- `STALL_CNT_W`, default 32: width of the performance counters (used only when counters are compiled in).

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `Rs1_D`, `Rs2_D` in 5: source register indices of the instruction in decode.
- `Rd_E` in 5: destination register index of the instruction in execute.
- `Mem_Read_E` in 1: the execute-stage instruction is a load.
- `PC_Src_E` in 1: taken branch or jump resolved in execute (redirect).
- `IMem_Ready` in 1: instruction memory returns a valid `Instr_F` this cycle.
- `DMem_Req_M` in 1: the memory-stage instruction is accessing data memory.
- `DMem_Ready` in 1: the data memory access completes this cycle.
- `Stall_F` out 1: hold the PC.
- `Stall_D` out 1: hold the fetch/decode register (its `Stall_En`).
- `Flush_D` out 1: load a NOP (0x00000013) into the fetch/decode register.
- `Stall_E` out 1: hold the decode/execute and execute/memory registers.
- `Flush_E` out 1: bubble the decode/execute register.
- `Stall_Count`, `Flush_Count` out `STALL_CNT_W`: performance counters (exist only with `HAZARD_PERF_CNT_EN`).

## Operation
- State register: RUN, DWAIT, IDROP. Reset state is RUN. Counters reset to 0.
- Outputs are combinational from the current state and current inputs. Only the state and the counters are registered.
- `Load_Use` = `Mem_Read_E` & (`Rd_E` != 0) & (`Rd_E` == `Rs1_D` | `Rd_E` == `Rs2_D`).
- `DMem_Busy` = `DMem_Req_M` & !`DMem_Ready`.

Priority of actions, highest first:
1. **`DMem_Busy`:**
   - Asserts `Stall_F`, `Stall_D`, `Stall_E`.
   - No flushes, even if `PC_Src_E` is high. The redirect is re-evaluated once the stall releases, because execute is frozen.
2. **`PC_Src_E`:**
   - Asserts `Flush_D` and `Flush_E`; `Stall_*` are 0.
   - Overrides `Load_Use`.
   - If `IMem_Ready`=0 in this cycle, the next state is IDROP.
3. **`Load_Use`:**
   - Asserts `Stall_F`, `Stall_D`, `Flush_E`.
   - Inserts exactly one bubble.
4. **`IMem_Ready`=0:**
   - Asserts `Stall_F` and `Flush_D`, injecting a NOP while the fetch is pending.
5. **Otherwise:** all outputs are 0.

State transitions:
- RUN→DWAIT when `DMem_Busy`. DWAIT→RUN when `DMem_Ready` is 1. The outputs in DWAIT follow rule 1 for as long as `DMem_Busy` holds.
- IDROP: the response from the fetch that was in flight at the redirect is stale.
  - While `IMem_Ready`=0 in IDROP: `Stall_F`=1, `Flush_D`=1.
  - On the first `IMem_Ready`=1 in IDROP: `Flush_D`=1, `Stall_F`=0 so the PC advances, and the next state is RUN.
  - Rules 1–3 still take priority inside IDROP.
  - A new `PC_Src_E` while in IDROP with `IMem_Ready`=0 keeps the state at IDROP.
- `RST` overrides everything. In the same cycle `RST` is high, all outputs are 0. On the next edge the state is RUN and the counters are 0, even mid-DWAIT or mid-IDROP.

## Timing
- Zero-cycle decision latency: controls are valid in the same cycle as their inputs and act at the next rising edge.
- A load-use stall lasts exactly 1 cycle. On the following cycle the load has moved to memory, so `Mem_Read_E` reflects the bubble and `Load_Use` drops.
- A redirect costs 2 bubbles (decode and execute), plus 1 extra for each cycle spent in IDROP.
- A data-memory wait of N cycles freezes the front end for N cycles. The first `DMem_Ready` cycle has no stall.
- `Stall_D` and `Flush_D` are never both 1. `Flush_D` wins over stall in the fetch/decode register, so the controller never asserts both.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `Stall_Count` increments in every cycle where `Stall_F`=1.
  - `Flush_Count` increments in every cycle where `Flush_E`=1 or the IDROP discard occurs.
  - Both counters wrap modulo 2^`STALL_CNT_W` and clear on `RST`.
- `HAZARD_PERF_CNT_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- **Load-use:** `Mem_Read_E`=1, `Rd_E`=5, `Rs2_D`=5 → one cycle of `Stall_F`=`Stall_D`=`Flush_E`=1, then all 0. Repeat with `Rd_E`=0 → no stall.
- **Redirect over load-use:** `PC_Src_E`=1 together with a load-use match → `Flush_D`=`Flush_E`=1, `Stall_F`=0.
- **Data-memory wait:**
  - `DMem_Req_M`=1 with `DMem_Ready` low for 3 cycles and `PC_Src_E`=1 → `Stall_F`/`Stall_D`/`Stall_E` high for 3 cycles with no flush.
  - On the 4th cycle (ready) → flushes appear.
- **IDROP discard:** `PC_Src_E`=1 while `IMem_Ready`=0, then `IMem_Ready` low for 2 more cycles, then high → `Flush_D`=1 for all 3 cycles; `Stall_F`=0 only in the ready cycle; state then RUN.
- **Reset mid-operation:** `RST` asserted in DWAIT → the next cycle, with inputs idle, all outputs are 0 and the state is RUN.
- **Counters (`HAZARD_PERF_CNT_EN`):** after the scenarios above → `Stall_Count` and `Flush_Count` equal the counted cycles. Force `Stall_Count` to 2^`STALL_CNT_W`−1 plus one stall → it wraps to 0.
